// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read port, a 3-bit control FSM and status/handshake flags.
// Define FIFO_ERR_CNT_EN to add saturating overflow/underflow event counters (wr_err_cnt, rd_err_cnt).
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [2:0]            state,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_CNT_EN
  output logic [7:0]            wr_err_cnt,
  output logic [7:0]            rd_err_cnt,
`endif
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101,
    ST_RW       = 3'b110,
    ST_ILLEGAL  = 3'b111
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  state_t                r_state, w_state_nxt;
  logic                  w_do_wr, w_do_rd, w_full, w_empty;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Actions and next state both derive from the pre-edge occupancy; an
  // illegal state spends one edge recovering to NO_OP without side effects.
  always_comb begin
    w_state_nxt = ST_NO_OP;
    w_do_wr     = 1'b0;
    w_do_rd     = 1'b0;
    if (r_state != ST_ILLEGAL) begin
      unique case ({wr_en, rd_en})
        2'b10: begin
          w_state_nxt = w_full ? ST_WR_ERROR : ST_WRITE;
          w_do_wr     = !w_full;
        end
        2'b01: begin
          w_state_nxt = w_empty ? ST_RD_ERROR : ST_READ;
          w_do_rd     = !w_empty;
        end
        2'b11: begin
          // Empty with both requests: write only, read silently dropped.
          w_state_nxt = w_empty ? ST_WRITE : ST_RW;
          w_do_wr     = 1'b1;
          w_do_rd     = !w_empty;
        end
        default: w_state_nxt = ST_NO_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_INIT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

`ifdef FIFO_ERR_CNT_EN
  logic [7:0] r_wr_err_cnt, r_rd_err_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_err_cnt <= '0;
      r_rd_err_cnt <= '0;
    end else begin
      if (w_state_nxt == ST_WR_ERROR && r_wr_err_cnt != 8'hFF) r_wr_err_cnt <= r_wr_err_cnt + 8'd1;
      if (w_state_nxt == ST_RD_ERROR && r_rd_err_cnt != 8'hFF) r_rd_err_cnt <= r_rd_err_cnt + 8'd1;
    end
  end

  assign wr_err_cnt = r_wr_err_cnt;
  assign rd_err_cnt = r_rd_err_cnt;
`endif

  assign dout         = r_dout;
  assign data_count   = r_count;
  assign state        = r_state;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign wr_ack       = (r_state == ST_WRITE) || (r_state == ST_RW);
  assign rd_ack       = (r_state == ST_READ)  || (r_state == ST_RW);
  assign wr_err       = (r_state == ST_WR_ERROR);
  assign rd_err       = (r_state == ST_RD_ERROR);

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (default 32x8, AF=6, AE=2).
// Covers FIFO_ERR_CNT_EN counters when that macro is defined.
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [31:0] din, dout;
  logic [3:0]  data_count;
  logic [2:0]  state;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ERR_CNT_EN
  logic [7:0]  wr_err_cnt, rd_err_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  localparam logic [2:0] S_INIT = 3'd0, S_NOP = 3'd1, S_WR = 3'd2, S_WRE = 3'd3,
                         S_RD = 3'd4, S_RDE = 3'd5, S_RW = 3'd6;

  fifo_param dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .data_count(data_count), .state(state),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef FIFO_ERR_CNT_EN
    .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt),
`endif
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive at the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    #1;
  endtask

  // Expected state, occupancy and output data; flags and handshakes follow from them.
  task automatic chk_all(input string tag, input logic [2:0] st, input int cnt, input logic [31:0] dv);
    chk({tag, " state"}, {29'd0, state}, {29'd0, st});
    chk({tag, " count"}, {28'd0, data_count}, 32'(cnt));
    chk({tag, " dout"}, dout, dv);
    chk({tag, " flags"}, {28'd0, full, empty, almost_full, almost_empty},
        {28'd0, cnt == 8, cnt == 0, cnt >= 6, cnt <= 2});
    chk({tag, " hs"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err},
        {28'd0, st == S_WR || st == S_RW, st == S_WRE, st == S_RD || st == S_RW, st == S_RDE});
  endtask

  initial begin
    wr_en = 0; rd_en = 0; din = '0;
    reset_n = 0;
    #2;
    chk_all("reset", S_INIT, 0, 32'h0);
    @(negedge clk); reset_n = 1;
    #1;
    chk_all("post_release", S_INIT, 0, 32'h0);
    step(0, 0, 0);
    chk_all("idle1", S_NOP, 0, 32'h0);
    step(0, 0, 0);
    chk_all("idle2", S_NOP, 0, 32'h0);

    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 32'h11 * k);
      chk_all($sformatf("fill%0d", k), S_WR, k, 32'h0);
    end
    step(1, 0, 32'h99);
    chk_all("overflow", S_WRE, 8, 32'h0);
`ifdef FIFO_ERR_CNT_EN
    chk("wr_err_cnt1", {24'd0, wr_err_cnt}, 32'd1);
`endif

    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0);
      chk_all($sformatf("drain%0d", k), S_RD, 8 - k, 32'h11 * k);
    end
    step(0, 1, 0);
    chk_all("underflow", S_RDE, 0, 32'h88);
`ifdef FIFO_ERR_CNT_EN
    chk("rd_err_cnt1", {24'd0, rd_err_cnt}, 32'd1);
`endif

    for (int k = 1; k <= 3; k++) step(1, 0, k);
    chk_all("pre_rw", S_WR, 3, 32'h88);
    for (int j = 0; j < 20; j++) begin
      step(1, 1, 32'(4 + j));
      chk_all($sformatf("rw%0d", j), S_RW, 3, 32'(1 + j));
    end

    // Holds 21,22,23; top up to full with 0x30..0x34.
    for (int k = 0; k < 5; k++) step(1, 0, 32'h30 + k);
    chk_all("refull", S_WR, 8, 32'h14);
    step(1, 1, 32'hAA);
    chk_all("rw_full", S_RW, 8, 32'h15);
    step(0, 1, 0);
    chk_all("rd_after_full_rw", S_RD, 7, 32'h16);
    for (int k = 0; k < 6; k++) step(0, 1, 0);
    chk_all("rd_0x34", S_RD, 1, 32'h34);
    step(0, 1, 0);
    chk_all("rd_0xAA", S_RD, 0, 32'hAA);
    step(1, 1, 32'hBB);
    chk_all("rw_empty", S_WR, 1, 32'hAA);

    for (int k = 0; k < 4; k++) step(1, 0, 32'hC0 + k);
    chk_all("count5", S_WR, 5, 32'hAA);
    // Asynchronous reset away from any clock edge.
    @(negedge clk); wr_en = 0; #2;
    reset_n = 0;
    #1;
    chk_all("async_reset", S_INIT, 0, 32'h0);
`ifdef FIFO_ERR_CNT_EN
    chk("err_cnt_reset", {16'd0, wr_err_cnt, rd_err_cnt}, 32'd0);
`endif
    @(negedge clk); reset_n = 1;
    step(0, 0, 0);
    chk_all("reset_idle", S_NOP, 0, 32'h0);
    step(1, 0, 32'hDEAD);
    step(0, 1, 0);
    chk_all("post_reset_rd", S_RD, 0, 32'hDEAD);

`ifdef FIFO_ERR_CNT_EN
    for (int k = 0; k < 8; k++) step(1, 0, k);
    for (int k = 0; k < 300; k++) step(1, 0, 32'hEE);
    chk_all("sat_state", S_WRE, 8, 32'hDEAD);
    chk("wr_err_sat", {24'd0, wr_err_cnt}, 32'd255);
    chk("rd_err_zero", {24'd0, rd_err_cnt}, 32'd0);
    @(negedge clk); wr_en = 0; reset_n = 0;
    #1;
    chk("wr_err_clr", {24'd0, wr_err_cnt}, 32'd0);
    @(negedge clk); reset_n = 1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO: storage array, read/write pointers, occupancy counter, 3-bit control FSM and status/handshake outputs in one block. Next generation of the 8-deep fixed FIFO. Adds configurable width and depth, simultaneous read+write, programmable almost-full/almost-empty thresholds and a registered read port. Sits between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of din/dout
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries
AF_LEVEL, 6, almost_full asserted when data_count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when data_count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
rd_en  input  1  read request
din  input  DATA_WIDTH  write data, sampled when write accepted
dout  output  DATA_WIDTH  registered read data
data_count  output  ADDR_WIDTH+1  current occupancy 0..DEPTH
state  output  3  FSM state (debug/visibility)
full, empty  output  1  combinational from data_count
almost_full, almost_empty  output  1  combinational from data_count
wr_ack, wr_err, rd_ack, rd_err  output  1  combinational decode of state

Behaviour:
- Reset (reset_n=0, async): state=INIT, pointers=0, data_count=0, dout=0; hence empty=1, almost_empty=1, full=0, almost_full=0, all ack/err=0. Memory contents not reset.
- States: INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101, RW=110; 111 unused, recovers to NO_OP next edge, outputs 0.
- Next state/action per edge, on pre-edge data_count:
  - wr_en=0, rd_en=0 -> NO_OP, no change.
  - wr_en only: not full -> WRITE, mem[wr_ptr]<=din, wr_ptr+1, count+1; full -> WR_ERROR, nothing changes.
  - rd_en only: not empty -> READ, dout<=mem[rd_ptr], rd_ptr+1, count-1; empty -> RD_ERROR, dout holds.
  - both, 0<count<DEPTH -> RW: write and read both performed, count unchanged.
  - both, full -> RW: read frees slot, write accepted same edge, count stays DEPTH.
  - both, empty -> WRITE only; read request dropped without error (no bypass).
- Outputs: wr_ack=1 in WRITE or RW; rd_ack=1 in READ or RW; wr_err=1 only in WR_ERROR; rd_err=1 only in RD_ERROR. All 0 in INIT/NO_OP.
- Read latency: one cycle; dout valid on the edge where rd_ack rises; dout holds last value otherwise.
- Pointers ADDR_WIDTH bits, wrap modulo DEPTH without special handling; count never exceeds DEPTH or goes below 0.
- full = (count==DEPTH), empty = (count==0); flags update same edge as count.
- Reset mid-operation: immediate return to reset values; first post-reset edge with no request -> NO_OP.

Optional Feature:
FIFO_ERR_CNT_EN: when defined, adds outputs wr_err_cnt[7:0] and rd_err_cnt[7:0]. Each increments on every edge entering WR_ERROR / RD_ERROR, saturates at 255, cleared only by reset_n. When undefined, ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then idle 2 cycles -> state INIT then NO_OP, empty=1, almost_empty=1, data_count=0, dout=0.
- Write 8 words 0x11..0x88 -> wr_ack each cycle, almost_full at count 6, full at count 8; 9th write 0x99 -> wr_err=1, count stays 8, dout unchanged.
- Read 8 from full -> dout 0x11..0x88 in order, one cycle after each rd_en; almost_empty at count 2; 9th read -> rd_err=1, dout holds 0x88.
- Write 3, then 20 cycles wr_en=rd_en=1 with incrementing data -> state RW, count fixed at 3, output stream in order across pointer wrap.
- Full FIFO, wr_en=rd_en=1 with din 0xAA -> RW, dout=oldest word, count 8; empty FIFO, both high with din 0xBB -> WRITE, rd_err=0, count 1.
- Assert reset_n=0 mid-stream at count 5 -> outputs return to reset values immediately without clock edge; with FIFO_ERR_CNT_EN, 300 overflow writes -> wr_err_cnt saturates at 255, cleared by reset.
